// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the alu: GPR file, source/dest decode,
// pending-write scoreboard and a one-entry valid/ready output register.
module alu_operand_stage #(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;

    logic [DATA_W-1:0] gpr [32];
    logic [31:0]       pending;
    logic [4:0]        out_dst;

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       is_rtype;
    logic       is_iwr;
    logic       is_shift;
    logic [4:0] dst;
    logic       use_rt;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       hz;
    logic       accept;

    assign op = in_instr[31:26];
    assign rs = in_instr[25:21];
    assign rt = in_instr[20:16];
    assign rd = in_instr[15:11];
    assign fn = in_instr[5:0];

    assign is_rtype = (op == OP_RTYPE);
    assign is_iwr   = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                 OP_ANDI, OP_ORI, OP_XORI, OP_LW};
    assign is_shift = is_rtype &&
                      (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});

    // Immediate ops write rt, so rt is not a source for them.
    always_comb begin
        dst    = 5'd0;
        use_rt = 1'b1;
        unique case (1'b1)
            is_rtype: dst = rd;
            is_iwr: begin
                dst    = rt;
                use_rt = 1'b0;
            end
            default: ;
        endcase
    end

    assign src_a = is_shift ? rt : rs;
    assign src_b = is_shift ? rs : rt;

    function automatic logic retiring(input logic [4:0] r);
        return BYPASS_EN && wb_en && (wb_addr == r);
    endfunction

    function automatic logic [DATA_W-1:0] read_gpr(input logic [4:0] r);
        if (r == 5'd0)
            return '0;
        if (retiring(r))
            return wb_data;
        return gpr[r];
    endfunction

    // Without bypass a retiring write is not visible yet, so it still stalls.
    assign hz = ((rs != 5'd0) && pending[rs] && !retiring(rs)) ||
                (use_rt && (rt != 5'd0) && pending[rt] && !retiring(rt)) ||
                ((dst != 5'd0) && pending[dst]);

    assign in_ready = !reset && !flush && !hz && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                gpr[i] <= '0;
            pending     <= '0;
            out_valid   <= 1'b0;
            out_dst     <= 5'd0;
            instruction <= '0;
            regA        <= '0;
            regB        <= '0;
        end else begin
            if (wb_en && (wb_addr != 5'd0))
                gpr[wb_addr] <= wb_data;
            if (wb_en)
                pending[wb_addr] <= 1'b0;
            if (flush && out_valid)
                pending[out_dst] <= 1'b0;
            // Issued destination set last so it wins over a same-cycle clear.
            if (accept && (dst != 5'd0))
                pending[dst] <= 1'b1;
            if (accept) begin
                out_valid   <= 1'b1;
                out_dst     <= dst;
                instruction <= in_instr;
                regA        <= read_gpr(src_a);
                regB        <= read_gpr(src_b);
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
